iter_divider: RTL and testbench

Iterative 32-bit signed/unsigned radix-2 restoring divider: the responder side of the execute stage's start/ready divide handshake. The ALU holds `start_i` high, stalling the pipeline, until this block pulses `ready_o` with `{remainder, quotient}` on `result_o`. The ALU then writes that value into HI/LO. The block is one clock domain and completes a non-zero divide in a fixed 33 cycles.

---
 rtl/iter_divider.sv | 124 ++++++++++++
 tb/tb_iter_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: iterative radix-2 restoring divider, signed or unsigned.
// Responds to a start/ready handshake. A non-zero divide takes 33 cycles
// from the first start_i cycle to the ready_o pulse. A zero divisor
// returns 0 after 2 cycles.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 annul_i,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DIVZERO = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  // {partial remainder (WIDTH+1 bits), quotient (WIDTH bits)}
  logic [2*WIDTH:0]     work_q;
  logic [2*WIDTH:0]     work_d;
  logic [WIDTH-1:0]     divisor_q;
  logic                 negq_q;
  logic                 negr_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH+1:0]     trial;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  // Operand magnitudes for the unsigned datapath; |-2^31| = 2^31 still fits.
  always_comb begin
    a_mag = opdata1_i;
    b_mag = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) a_mag = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) b_mag = -opdata2_i;
  end

  // One restoring step: shift left, trial-subtract the divisor from the
  // upper bits, keep the difference and set quotient bit 0 when it is
  // non-negative. The trial is one bit wider than the partial remainder,
  // so its MSB serves as the borrow/sign flag.
  always_comb begin
    trial = work_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
    if (trial[WIDTH+1]) begin
      work_d = {work_q[2*WIDTH-1:0], 1'b0};
    end else begin
      work_d = {trial[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction of the final iteration's quotient and remainder (mod 2^WIDTH).
  always_comb begin
    q_fix = work_d[WIDTH-1:0];
    r_fix = work_d[2*WIDTH-1:WIDTH];
    if (negq_q) q_fix = -work_d[WIDTH-1:0];
    if (negr_q) r_fix = -work_d[2*WIDTH-1:WIDTH];
  end

  // Control FSM plus datapath registers; reset beats abort beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush || annul_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_q <= S_DIVZERO;
            end else begin
              state_q   <= S_BUSY;
              cnt_q     <= '0;
              work_q    <= {{(WIDTH+1){1'b0}}, a_mag};
              divisor_q <= b_mag;
              negq_q    <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              negr_q    <= signed_div_i && opdata1_i[WIDTH-1];
            end
          end
        end
        S_BUSY: begin
          if (!start_i) begin
            state_q <= S_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
              state_q  <= S_DONE;
              result_q <= {r_fix, q_fix};
            end
          end
        end
        S_DIVZERO: begin
          result_q <= '0;
          state_q  <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table-driven, hand-written and randomized checks of
// iter_divider against a plain-arithmetic reference model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        annul_i;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        ready_o;
  logic [63:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .annul_i      (annul_i),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .ready_o      (ready_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t tbl[8];

  // Reference: language-level division (truncating toward zero), low 32 bits kept.
  function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one divide from IDLE, waits for ready_o, checks latency and result.
  // Returns positioned 1 time unit into the DONE cycle with start_i low.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int exp_lat, input string name);
    int cyc;
    @(posedge clk); #1;
    chk({name, " ready low before start"}, {63'h0, ready_o}, 64'h0);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        // late operand changes must not matter
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end
    start_i = 1'b0;
    if (!ready_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no ready_o within %0d cycles", name, cyc);
    end else begin
      chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({name, " result"}, result_o, exp);
    end
  endtask

  // Starts 123/4 and kills it at cycle 10 by flush (0), start low (1) or annul (2).
  task automatic run_abort(input int mode, input logic [63:0] prev, input string name);
    logic seen;
    @(posedge clk); #1;
    opdata1_i    = 32'd123;
    opdata2_i    = 32'd4;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    case (mode)
      0:       flush   = 1'b1;
      1:       start_i = 1'b0;
      default: annul_i = 1'b1;
    endcase
    @(posedge clk); #1;
    flush   = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (ready_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk({name, " no ready"}, {63'h0, seen}, 64'h0);
    chk({name, " result kept"}, result_o, prev);
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, {name, " follow-up 50/5"});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0] = '{32'd100,       32'd7,         1'b0, {32'd2, 32'd14},                 33, "u 100/7"};
    tbl[1] = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, "s -7/2"};
    tbl[2] = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD},          33, "s 7/-2"};
    tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000},          33, "s min/-1"};
    tbl[4] = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0, 32'hFFFF_FFFF},          33, "u max/1"};
    tbl[5] = '{32'd1000,      32'd7,         1'b0, {32'd6, 32'd142},                33, "u 1000/7"};
    tbl[6] = '{32'd55,        32'd0,         1'b0, 64'h0,                           2,  "u div0"};
    tbl[7] = '{32'hFFFF_FF00, 32'd0,         1'b1, 64'h0,                           2,  "s div0"};

    rst = 1'b1; flush = 1'b0; annul_i = 1'b0; start_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset ready", {63'h0, ready_o}, 64'h0);
    chk("reset result", result_o, 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_div(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, tbl[i].lat, tbl[i].name);
    end

    // ready_o is a single-cycle pulse
    @(posedge clk); #1;
    chk("ready one-cycle", {63'h0, ready_o}, 64'h0);

    run_div(32'd1000, 32'd7, 1'b0, {32'd6, 32'd142}, 33, "pre-abort");
    run_abort(0, {32'd6, 32'd142}, "flush@10");
    run_abort(1, {32'd0, 32'd10},  "startlow@10");
    run_abort(2, {32'd0, 32'd10},  "annul@10");

    // back-to-back: next start in the first IDLE cycle after ready_o
    run_div(32'd9,    32'd4, 1'b0, {32'd1, 32'd2},   33, "b2b 9/4");
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, "b2b 1000/3");

    // reset in the middle of BUSY
    @(posedge clk); #1;
    opdata1_i = 32'd77; opdata2_i = 32'd5; signed_div_i = 1'b0; start_i = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    chk("mid-busy rst ready", {63'h0, ready_o}, 64'h0);
    chk("mid-busy rst result", result_o, 64'h0);
    run_div(32'd77, 32'd5, 1'b0, {32'd2, 32'd15}, 33, "post-rst 77/5");

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 3);
        1:       rb = $urandom;
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = -($urandom_range(1, 9));
      endcase
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, ref_div(ra, rb, rs), (rb == 32'd0) ? 2 : 33, "random");
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
